ysyx_22050243_dmem: RTL and testbench

Parametrised, synthesisable data memory for the NPC MEM stage, the next generation of the DPI-backed pmem access block. Exposes a valid/ready request channel and a valid/ready response channel with configurable access latency and byte-masked writes. Internal word array of DEPTH entries, mapped at BASE_ADDR. One outstanding request at a time.

---
 rtl/ysyx_22050243_dmem_pkg.sv | 25 ++
 rtl/ysyx_22050243_bytemask_ram.sv | 52 +++++
 rtl/ysyx_22050243_dmem.sv | 132 +++++++++++++
 tb/tb_ysyx_22050243_dmem.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050243_dmem_pkg.sv
// Shared types and sizing helpers for the NPC data memory (ysyx_22050243_dmem).
package ysyx_22050243_dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

    function automatic int bytes_of(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int idx_w_of(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int off_w_of(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/ysyx_22050243_bytemask_ram.sv
// DEPTH x DATA_W word array with per-byte write enable and a registered
// read-before-write port: rdata returns the word as it stood before the same edge's write.
module ysyx_22050243_bytemask_ram
    import ysyx_22050243_dmem_pkg::*;
#(
    parameter int  DATA_W = 64,
    parameter int  DEPTH  = 4096,
    localparam int BYTES  = bytes_of(DATA_W),
    localparam int IDX_W  = idx_w_of(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [BYTES-1:0]  we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the array is deliberately left out of reset so it maps onto RAM macros/BRAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTES; i++) begin
            if (en && we[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // NOTE: combinational blocks use blocking '=' and give every output a value on
    // every path, so no latch is inferred; clocked blocks use '<=' only.
    always_comb begin
        rdata_d = rdata_q;
        if (en) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ysyx_22050243_dmem.sv
// NPC MEM-stage data memory: valid/ready request and response channels, fixed LATENCY,
// byte-masked writes. Define YSYX_22050243_DMEM_ERR_EN to enable range/alignment errors.
module ysyx_22050243_dmem
    import ysyx_22050243_dmem_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter int                ADDR_W    = 64,
    parameter int                DEPTH     = 4096,
    parameter int                LATENCY   = 1,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000,
    localparam int               BYTES     = bytes_of(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [BYTES-1:0]  req_wmask,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int                IDX_W    = idx_w_of(DEPTH);
    localparam int                OFF_W    = off_w_of(DATA_W);
    localparam int                CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);
    localparam logic [ADDR_W-1:0] SPAN     = ADDR_W'(DEPTH * BYTES);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(BYTES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              accept;
    logic              addr_err;
    logic [ADDR_W-1:0] offset;
    logic [IDX_W-1:0]  idx;
    logic [BYTES-1:0]  wmask_eff;
    logic [DATA_W-1:0] ram_rdata;
    logic              unused_offset;

    assign offset        = req_addr - BASE_ADDR;
    assign idx           = offset[OFF_W +: IDX_W];
    assign unused_offset = ^offset;
    assign accept        = req_valid && req_ready;

`ifdef YSYX_22050243_DMEM_ERR_EN
    // Addresses below BASE_ADDR wrap to huge offsets, so one compare covers both ends.
    assign addr_err = (offset >= SPAN) || ((req_addr & LOW_MASK) != '0);
`else
    assign addr_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= RSP_OK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d   = '0;
                    state_d = (LATENCY > 1) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: req_ready = rst_n;
            ST_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        err_d     = err_q;
        wmask_eff = '0;
        if (accept) begin
            err_d = addr_err ? RSP_ERR : RSP_OK;
            if (req_we && !addr_err) begin
                wmask_eff = req_wmask;
            end
        end
    end

    ysyx_22050243_bytemask_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .we    (wmask_eff),
        .addr  (idx),
        .wdata (req_wdata),
        .rdata (ram_rdata)
    );

    assign rsp_rdata = err_q ? '0 : ram_rdata;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_ysyx_22050243_dmem.sv
// Directed self-checking bench for ysyx_22050243_dmem with DATA_W=64, LATENCY=2.
module tb_ysyx_22050243_dmem;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_wmask;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    ysyx_22050243_dmem #(
        .DATA_W    (64),
        .ADDR_W    (64),
        .DEPTH     (4096),
        .LATENCY   (2),
        .BASE_ADDR (64'h8000_0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_wmask (req_wmask),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // One full transaction with rsp_ready high; lat counts cycles from the accept cycle.
    task automatic xact(input logic we, input logic [7:0] mask, input logic [63:0] addr,
                        input logic [63:0] wdata, output logic [63:0] rdata,
                        output logic err, output int lat, output bit to);
        int n;
        to    = 1'b0;
        lat   = 0;
        rdata = '0;
        err   = 1'b0;
        n     = 0;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_we    = we;
        req_wmask = mask;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            to        = 1'b1;
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat       = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            to = 1'b1;
            return;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        total++; if (rsp_rdata !== 64'h0) begin bad++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_write_read();
        logic [63:0] rd;
        logic        er;
        int          lat;
        bit          to;
        xact(1'b1, 8'hFF, 64'h8000_0010, 64'h1122_3344_5566_7788, rd, er, lat, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL wr_timeout: got %b expected 0", to); end
        total++; if (lat != 2) begin bad++; $display("FAIL wr_latency: got %0d expected 2", lat); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL wr_err: got %b expected 0", er); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_valid_drop: got %b expected 0", rsp_valid); end
        xact(1'b0, 8'h00, 64'h8000_0010, 64'h0, rd, er, lat, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL rd_timeout: got %b expected 0", to); end
        total++; if (lat != 2) begin bad++; $display("FAIL rd_latency: got %0d expected 2", lat); end
        total++; if (rd !== 64'h1122_3344_5566_7788) begin bad++; $display("FAIL rd_data: got %h expected 1122334455667788", rd); end
    endtask

    task automatic test_partial_write();
        logic [63:0] rd;
        logic        er;
        int          lat;
        bit          to;
        xact(1'b1, 8'h0F, 64'h8000_0010, 64'hAAAA_AAAA_BBBB_BBBB, rd, er, lat, to);
        total++; if (rd !== 64'h1122_3344_5566_7788) begin bad++; $display("FAIL pw_old_value: got %h expected 1122334455667788", rd); end
        xact(1'b0, 8'h00, 64'h8000_0010, 64'h0, rd, er, lat, to);
        total++; if (rd !== 64'h1122_3344_BBBB_BBBB) begin bad++; $display("FAIL pw_merged: got %h expected 11223344bbbbbbbb", rd); end
        xact(1'b1, 8'h00, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, rd, er, lat, to);
        total++; if (lat != 2) begin bad++; $display("FAIL zero_mask_latency: got %0d expected 2", lat); end
        xact(1'b0, 8'h00, 64'h8000_0010, 64'h0, rd, er, lat, to);
        total++; if (rd !== 64'h1122_3344_BBBB_BBBB) begin bad++; $display("FAIL zero_mask_kept: got %h expected 11223344bbbbbbbb", rd); end
    endtask

    task automatic test_hold();
        logic [63:0] rd;
        logic        er;
        int          lat;
        bit          to;
        int          n;
        n = 0;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 64'h8000_0010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL hold_rsp_arrive: got %b expected 1", rsp_valid); end
        for (int i = 0; i < 5; i++) begin
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, rsp_valid); end
            total++; if (rsp_rdata !== 64'h1122_3344_BBBB_BBBB) begin bad++; $display("FAIL hold_rdata[%0d]: got %h expected 11223344bbbbbbbb", i, rsp_rdata); end
            total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL hold_err[%0d]: got %b expected 0", i, rsp_err); end
            total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL hold_req_ready[%0d]: got %b expected 0", i, req_ready); end
            req_valid = (i == 1);
            req_we    = 1'b1;
            req_wmask = 8'hFF;
            req_wdata = 64'h0;
            @(negedge clk);
        end
        req_valid = 1'b0;
        req_we    = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL hold_release_valid: got %b expected 0", rsp_valid); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL hold_release_ready: got %b expected 1", req_ready); end
        xact(1'b0, 8'h00, 64'h8000_0010, 64'h0, rd, er, lat, to);
        total++; if (rd !== 64'h1122_3344_BBBB_BBBB) begin bad++; $display("FAIL hold_pulse_ignored: got %h expected 11223344bbbbbbbb", rd); end
    endtask

    // Accept a request, then pull reset while the FSM sits in WAIT.
    task automatic reset_in_wait(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_we    = we;
        req_wmask = 8'hFF;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_wait_valid: got %b expected 0", rsp_valid); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_wait_ready: got %b expected 0", req_ready); end
        total++; if (rsp_rdata !== 64'h0) begin bad++; $display("FAIL rst_wait_rdata: got %h expected 0", rsp_rdata); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b expected 1", req_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_stale_rsp[%0d]: got %b expected 0", i, rsp_valid); end
        end
    endtask

    task automatic test_reset_wait();
        logic [63:0] rd;
        logic        er;
        int          lat;
        bit          to;
        reset_in_wait(1'b0, 64'h8000_0010, 64'h0);
        reset_in_wait(1'b1, 64'h8000_0018, 64'hCAFE_BABE_DEAD_BEEF);
        xact(1'b0, 8'h00, 64'h8000_0018, 64'h0, rd, er, lat, to);
        total++; if (rd !== 64'hCAFE_BABE_DEAD_BEEF) begin bad++; $display("FAIL rst_write_kept: got %h expected cafebabedeadbeef", rd); end
    endtask

    task automatic test_err();
        logic [63:0] rd;
        logic        er;
        int          lat;
        bit          to;
        xact(1'b1, 8'hFF, 64'h8000_0000, 64'h0123_4567_89AB_CDEF, rd, er, lat, to);
`ifdef YSYX_22050243_DMEM_ERR_EN
        xact(1'b0, 8'h00, 64'h8000_0003, 64'h0, rd, er, lat, to);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL err_misaligned: got %b expected 1", er); end
        total++; if (rd !== 64'h0) begin bad++; $display("FAIL err_misaligned_data: got %h expected 0", rd); end
        total++; if (lat != 2) begin bad++; $display("FAIL err_latency: got %0d expected 2", lat); end
        xact(1'b0, 8'h00, 64'h7FFF_FFF8, 64'h0, rd, er, lat, to);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL err_below_base: got %b expected 1", er); end
        total++; if (rd !== 64'h0) begin bad++; $display("FAIL err_below_base_data: got %h expected 0", rd); end
        xact(1'b1, 8'hFF, 64'h8000_8000, 64'hFFFF_FFFF_FFFF_FFFF, rd, er, lat, to);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL err_above_range: got %b expected 1", er); end
        xact(1'b0, 8'h00, 64'h8000_0000, 64'h0, rd, er, lat, to);
        total++; if (rd !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("FAIL err_write_suppressed: got %h expected 0123456789abcdef", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL err_clear: got %b expected 0", er); end
`else
        xact(1'b0, 8'h00, 64'h8000_0003, 64'h0, rd, er, lat, to);
        total++; if (rd !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("FAIL low_bits_ignored: got %h expected 0123456789abcdef", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL no_err_flag: got %b expected 0", er); end
`endif
    endtask

    task automatic test_alias();
        logic [63:0] rd;
        logic        er;
        int          lat;
        bit          to;
        xact(1'b1, 8'hFF, 64'h8000_8000, 64'h5A5A_0F0F_A5A5_F0F0, rd, er, lat, to);
        total++; if (rd !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("FAIL alias_old_word0: got %h expected 0123456789abcdef", rd); end
        xact(1'b0, 8'h00, 64'h8000_0000, 64'h0, rd, er, lat, to);
        total++; if (rd !== 64'h5A5A_0F0F_A5A5_F0F0) begin bad++; $display("FAIL alias_word0: got %h expected 5a5a0f0fa5a5f0f0", rd); end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_wmask = 8'h00;
        req_addr  = 64'h0;
        req_wdata = 64'h0;
        rsp_ready = 1'b1;
        test_reset();
        test_write_read();
        test_partial_write();
        test_hold();
        test_reset_wait();
        test_err();
`ifndef YSYX_22050243_DMEM_ERR_EN
        test_alias();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
